// File: rtl/pb_encoder.sv
// Pushbutton priority encoder: synchronizes the 21 raw button levels, debounces
// press and release, emits the highest pressed index as a 5-bit key code with a
// one-cycle strobe, and maintains an 8-nibble hex entry register.
module pb_encoder #(
   parameter int DEBOUNCE = 2  // stable cycles to accept a press/release, 1..15
) (
   input  logic        hz100,
   input  logic        reset,
   input  logic [20:0] pb,
   output logic [4:0]  code,
   output logic        strobe,
   output logic        pressed,
   output logic [31:0] digits,
   output logic [3:0]  ndigits
);

   typedef enum logic [1:0] {
      IDLE,
      DB_PRESS,
      HELD,
      DB_RELEASE
   } state_t;

   localparam logic [3:0] DB_CNT    = 4'(DEBOUNCE);
   localparam logic [4:0] KEY_BKSP  = 5'd16;
   localparam logic [4:0] KEY_CLEAR = 5'd17;

   logic [20:0] s1_q, s1_d;
   logic [20:0] s2_q, s2_d;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  cand_q, cand_d;
   logic [4:0]  code_q, code_d;
   logic        strobe_q, strobe_d;
   logic        pressed_q, pressed_d;
   logic [31:0] digits_q, digits_d;
   logic [3:0]  ndigits_q, ndigits_d;

   logic        any;
   logic [4:0]  enc;

   // Priority encode the synchronized levels: highest set index wins.
   always_comb begin
      enc = '0;
      for (int i = 0; i < 21; i++) begin
         if (s2_q[i]) enc = 5'(i);
      end
   end

   assign any = |s2_q;

   // Next-state logic for the synchronizer, debounce FSM, outputs and digit register.
   always_comb begin
      // NOTE: every signal gets a default up front so no branch leaves one unassigned, which would infer a latch.
      s1_d      = pb;
      s2_d      = s1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      code_d    = code_q;
      strobe_d  = 1'b0;
      pressed_d = pressed_q;
      digits_d  = digits_q;
      ndigits_d = ndigits_q;

      unique case (state_q)
         IDLE: begin
            if (any) begin
               state_d = DB_PRESS;
               cand_d  = enc;
               cnt_d   = 4'd1;
            end
         end

         DB_PRESS: begin
            if (!any) begin
               state_d = IDLE;
            end else if (enc != cand_q) begin
               // Highest index moved: restart the debounce on the new candidate.
               cand_d = enc;
               cnt_d  = 4'd1;
            end else if (cnt_q == DB_CNT) begin
               state_d   = HELD;
               code_d    = cand_q;
               strobe_d  = 1'b1;
               pressed_d = 1'b1;
               if (cand_q <= 5'd15) begin
                  digits_d = {digits_q[27:0], cand_q[3:0]};
                  if (ndigits_q != 4'd8) ndigits_d = ndigits_q + 4'd1;
               end else if (cand_q == KEY_BKSP) begin
                  digits_d = {4'h0, digits_q[31:4]};
                  if (ndigits_q != 4'd0) ndigits_d = ndigits_q - 4'd1;
               end else if (cand_q == KEY_CLEAR) begin
                  digits_d  = '0;
                  ndigits_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         HELD: begin
            // Changes among held buttons are ignored; only full release matters.
            if (!any) begin
               state_d = DB_RELEASE;
               cnt_d   = 4'd1;
            end
         end

         DB_RELEASE: begin
            if (any) begin
               state_d = HELD;
            end else if (cnt_q == DB_CNT) begin
               state_d   = IDLE;
               pressed_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge hz100) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         cand_q    <= '0;
         code_q    <= '0;
         strobe_q  <= 1'b0;
         pressed_q <= 1'b0;
         digits_q  <= '0;
         ndigits_q <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cand_q    <= cand_d;
         code_q    <= code_d;
         strobe_q  <= strobe_d;
         pressed_q <= pressed_d;
         digits_q  <= digits_d;
         ndigits_q <= ndigits_d;
      end
   end

   assign code    = code_q;
   assign strobe  = strobe_q;
   assign pressed = pressed_q;
   assign digits  = digits_q;
   assign ndigits = ndigits_q;

endmodule
